// File: rtl/proc_pkg.sv
// Shared processor constants and types for the fetch stage.
package proc_pkg;

  localparam int unsigned AWL = 5;
  localparam int unsigned DW  = 32;

  localparam logic [AWL-1:0] RESET_PC = '0;
  localparam logic [DW-1:0]  NOP_INST = '0;

  typedef logic [AWL-1:0] pc_t;
  typedef logic [DW-1:0]  inst_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: holds under backpressure, flushes to NOP on
// redirect, and empties to NOP when drained without a new fetch.
module if_id_reg
  import proc_pkg::*;
#(
  parameter int unsigned    DW       = proc_pkg::DW,
  parameter int unsigned    AWL      = proc_pkg::AWL,
  parameter logic [DW-1:0]  NOP_INST = proc_pkg::NOP_INST
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  input  logic           load,
  input  logic           drain,
  input  logic [DW-1:0]  d_inst,
  input  logic [AWL-1:0] d_pc,
  output logic           q_valid,
  output logic [DW-1:0]  q_inst,
  output logic [AWL-1:0] q_pc,
  output logic [AWL-1:0] q_pc_plus1
);

  // flush > load > drain; pc fields are only rewritten by a load or reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_valid    <= 1'b0;
      q_inst     <= NOP_INST;
      q_pc       <= '0;
      q_pc_plus1 <= '0;
    end else if (flush) begin
      q_valid <= 1'b0;
      q_inst  <= NOP_INST;
    end else if (load) begin
      q_valid    <= 1'b1;
      q_inst     <= d_inst;
      q_pc       <= d_pc;
      q_pc_plus1 <= d_pc + AWL'(1);
    end else if (drain) begin
      q_valid <= 1'b0;
      q_inst  <= NOP_INST;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, next-PC selection and IF/ID register.
// Optional fetched-instruction counter enabled by macro FETCH_CNT_EN.
module fetch_unit
  import proc_pkg::*;
#(
  parameter int unsigned    DW       = proc_pkg::DW,
  parameter int unsigned    AWL      = proc_pkg::AWL,
  parameter logic [AWL-1:0] RESET_PC = proc_pkg::RESET_PC,
  parameter logic [DW-1:0]  NOP_INST = proc_pkg::NOP_INST
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  output logic [AWL-1:0] IMA,
  input  logic [DW-1:0]  IMRD,
  input  logic           redirect_valid,
  input  logic [AWL-1:0] redirect_pc,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [DW-1:0]  inst_out,
  output logic [AWL-1:0] pc_out,
  output logic [AWL-1:0] pc_plus1_out,
  output logic [31:0]    fetch_count
);

  logic [AWL-1:0] pc_q;
  logic           accept;
  logic           drain;

  assign accept = en & (~out_valid | out_ready);
  assign drain  = out_valid & out_ready & ~en;
  assign IMA    = pc_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else if (redirect_valid) begin
      pc_q <= redirect_pc;
    end else if (accept) begin
      pc_q <= pc_q + AWL'(1);
    end
  end

  if_id_reg #(
    .DW       (DW),
    .AWL      (AWL),
    .NOP_INST (NOP_INST)
  ) u_if_id (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (redirect_valid),
    .load       (accept),
    .drain      (drain),
    .d_inst     (IMRD),
    .d_pc       (pc_q),
    .q_valid    (out_valid),
    .q_inst     (inst_out),
    .q_pc       (pc_out),
    .q_pc_plus1 (pc_plus1_out)
  );

`ifdef FETCH_CNT_EN
  logic [31:0] cnt_q;

  // a fetch overridden by a redirect is discarded and not counted
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (accept && !redirect_valid) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign fetch_count = cnt_q;
`else
  assign fetch_count = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, counter sequence
// and randomized traffic against a queue-based reference model.
module tb_fetch_unit;
  import proc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, en, redirect_valid, out_ready;
  pc_t         redirect_pc, ima, pc_out, pc_plus1_out;
  inst_t       imrd, inst_out;
  logic        out_valid;
  logic [31:0] fetch_count;

  inst_t mem [32];
  assign imrd = mem[ima];

  always #5 clk = ~clk;

  fetch_unit #(
    .DW       (DW),
    .AWL      (AWL),
    .RESET_PC (RESET_PC),
    .NOP_INST (NOP_INST)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .en             (en),
    .IMA            (ima),
    .IMRD           (imrd),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .inst_out       (inst_out),
    .pc_out         (pc_out),
    .pc_plus1_out   (pc_plus1_out),
    .fetch_count    (fetch_count)
  );

  int unsigned errors = 0;
  int unsigned checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the IF/ID register is a queue of at most one entry.
  typedef struct {
    inst_t inst;
    pc_t   pc;
  } entry_t;

  entry_t      mq[$];
  pc_t         m_pc, m_pcout, m_pc1;
  logic [31:0] m_cnt;

  task automatic model_edge();
    entry_t e;
    if (!rst_n) begin
      m_pc = RESET_PC; mq.delete(); m_pcout = '0; m_pc1 = '0; m_cnt = 0;
    end else if (redirect_valid) begin
      m_pc = redirect_pc; mq.delete();
    end else if (en && (mq.size() == 0 || out_ready)) begin
      e.inst = mem[m_pc]; e.pc = m_pc;
      mq.delete(); mq.push_back(e);
      m_pcout = m_pc;
      m_pc1   = pc_t'((int'(m_pc) + 1) % 32);
      m_pc    = m_pc1;
      m_cnt   = m_cnt + 1;
    end else if (mq.size() != 0 && out_ready && !en) begin
      mq.delete();
    end
  endtask

  function automatic logic [31:0] exp_count();
`ifdef FETCH_CNT_EN
    return m_cnt;
`else
    return 32'd0;
`endif
  endfunction

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check("model_valid", 64'(out_valid), 64'(mq.size() != 0));
    check("model_inst", 64'(inst_out), 64'((mq.size() != 0) ? mq[0].inst : NOP_INST));
    check("model_ima", 64'(ima), 64'(m_pc));
    check("model_pc_out", 64'(pc_out), 64'(m_pcout));
    check("model_pc_plus1", 64'(pc_plus1_out), 64'(m_pc1));
    check("model_fetch_count", 64'(fetch_count), 64'(exp_count()));
  endtask

  typedef struct {
    logic  rst_n, en, rdy, rv;
    pc_t   rpc;
    logic  chk_pc;
    logic  v;
    inst_t inst;
    pc_t   pcout, pc1, ima;
  } vec_t;

  function automatic vec_t mk(logic r, logic e, logic rd, logic rv, int rpc, logic cp,
                              logic v, int inst, int pco, int pc1, int im);
    vec_t t;
    t.rst_n = r; t.en = e; t.rdy = rd; t.rv = rv; t.rpc = pc_t'(rpc); t.chk_pc = cp;
    t.v = v; t.inst = inst_t'(inst); t.pcout = pc_t'(pco); t.pc1 = pc_t'(pc1); t.ima = pc_t'(im);
    return t;
  endfunction

  vec_t tbl[$];

  initial begin
    rst_n = 1'b0; en = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    for (int k = 0; k < 32; k++) mem[k] = inst_t'(k);

    //                rst en rdy rv rpc chk  v inst pco pc1 ima
    tbl.push_back(mk(0, 1, 1, 0, 0,  1, 0, 0,  0,  0,  0));
    tbl.push_back(mk(0, 1, 1, 0, 0,  1, 0, 0,  0,  0,  0));
    tbl.push_back(mk(1, 1, 1, 0, 0,  1, 1, 0,  0,  1,  1));
    tbl.push_back(mk(1, 1, 1, 0, 0,  1, 1, 1,  1,  2,  2));
    tbl.push_back(mk(1, 1, 1, 0, 0,  1, 1, 2,  2,  3,  3));
    tbl.push_back(mk(1, 1, 1, 0, 0,  1, 1, 3,  3,  4,  4));
    tbl.push_back(mk(1, 1, 1, 0, 0,  1, 1, 4,  4,  5,  5));
    tbl.push_back(mk(1, 1, 1, 0, 0,  1, 1, 5,  5,  6,  6));
    tbl.push_back(mk(1, 1, 0, 0, 0,  1, 1, 5,  5,  6,  6));
    tbl.push_back(mk(1, 1, 0, 0, 0,  1, 1, 5,  5,  6,  6));
    tbl.push_back(mk(1, 1, 0, 0, 0,  1, 1, 5,  5,  6,  6));
    tbl.push_back(mk(1, 1, 1, 0, 0,  1, 1, 6,  6,  7,  7));
    tbl.push_back(mk(1, 1, 1, 0, 0,  1, 1, 7,  7,  8,  8));
    tbl.push_back(mk(1, 1, 1, 0, 0,  1, 1, 8,  8,  9,  9));
    tbl.push_back(mk(1, 1, 1, 1, 20, 0, 0, 0,  0,  0,  20));
    tbl.push_back(mk(1, 1, 1, 0, 0,  1, 1, 20, 20, 21, 21));
    tbl.push_back(mk(1, 1, 1, 0, 0,  1, 1, 21, 21, 22, 22));
    tbl.push_back(mk(1, 1, 0, 0, 0,  1, 1, 21, 21, 22, 22));
    tbl.push_back(mk(1, 1, 0, 1, 30, 0, 0, 0,  0,  0,  30));
    tbl.push_back(mk(1, 1, 1, 0, 0,  1, 1, 30, 30, 31, 31));
    tbl.push_back(mk(1, 1, 1, 0, 0,  1, 1, 31, 31, 0,  0));
    tbl.push_back(mk(1, 1, 1, 0, 0,  1, 1, 0,  0,  1,  1));
    tbl.push_back(mk(1, 1, 1, 0, 0,  1, 1, 1,  1,  2,  2));
    tbl.push_back(mk(1, 0, 1, 0, 0,  0, 0, 0,  0,  0,  2));
    tbl.push_back(mk(1, 0, 1, 0, 0,  0, 0, 0,  0,  0,  2));
    tbl.push_back(mk(1, 1, 1, 0, 0,  1, 1, 2,  2,  3,  3));
    tbl.push_back(mk(1, 1, 0, 0, 0,  1, 1, 2,  2,  3,  3));
    tbl.push_back(mk(0, 1, 0, 0, 0,  1, 0, 0,  0,  0,  0));
    tbl.push_back(mk(1, 1, 1, 0, 0,  1, 1, 0,  0,  1,  1));
    tbl.push_back(mk(1, 0, 0, 1, 12, 0, 0, 0,  0,  0,  12));
    tbl.push_back(mk(1, 1, 1, 0, 0,  1, 1, 12, 12, 13, 13));

    foreach (tbl[i]) begin
      rst_n = tbl[i].rst_n; en = tbl[i].en; out_ready = tbl[i].rdy;
      redirect_valid = tbl[i].rv; redirect_pc = tbl[i].rpc;
      step();
      check($sformatf("vec%0d_valid", i), 64'(out_valid), 64'(tbl[i].v));
      check($sformatf("vec%0d_inst", i), 64'(inst_out), 64'(tbl[i].inst));
      check($sformatf("vec%0d_ima", i), 64'(ima), 64'(tbl[i].ima));
      if (tbl[i].chk_pc) begin
        check($sformatf("vec%0d_pc_out", i), 64'(pc_out), 64'(tbl[i].pcout));
        check($sformatf("vec%0d_pc_plus1", i), 64'(pc_plus1_out), 64'(tbl[i].pc1));
      end
    end

    // counter: 10 fetches then a redirect that discards the in-flight fetch
    rst_n = 1'b0; en = 1'b0; out_ready = 1'b1; redirect_valid = 1'b0;
    step();
    check("cnt_after_reset", 64'(fetch_count), 64'd0);
    rst_n = 1'b1; en = 1'b1;
    for (int i = 0; i < 10; i++) step();
    redirect_valid = 1'b1; redirect_pc = pc_t'(3);
    step();
`ifdef FETCH_CNT_EN
    check("cnt_ten_fetches", 64'(fetch_count), 64'd10);
`else
    check("cnt_tied_zero", 64'(fetch_count), 64'd0);
`endif
    check("cnt_redirect_ima", 64'(ima), 64'd3);
    redirect_valid = 1'b0;
    step();
    check("cnt_after_redirect_inst", 64'(inst_out), 64'd3);

    // randomized traffic with random memory contents
    for (int k = 0; k < 32; k++) mem[k] = inst_t'($urandom);
    for (int i = 0; i < 600; i++) begin
      rst_n          = ($urandom_range(0, 63) != 0);
      en             = ($urandom_range(0, 5) != 0);
      out_ready      = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 11) == 0);
      redirect_pc    = pc_t'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
